// File: rtl/t_flipflop.sv
// Bank of WIDTH independent toggle flip-flops with a complementary output.
// Per-bit next state is q ^ t. The async active-low reset loads RST_VAL.
module t_flipflop #(
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  assign w_q_next = r_q ^ t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= w_q_next;
    end
  end

  // q_bar is derived from the same register so the two can never agree.
  assign q     = r_q;
  assign q_bar = ~r_q;

endmodule

// File: tb/tb_t_flipflop.sv
// Directed bench for t_flipflop: single-bit default instance and a 4-bit
// instance with RST_VAL = 4'b1010, checked through an expected-value queue.
module tb_t_flipflop;

  logic       clk;
  logic       rst1_n;
  logic       t1;
  logic       q1;
  logic       qb1;
  logic       rst4_n;
  logic [3:0] t4;
  logic [3:0] q4;
  logic [3:0] qb4;

  typedef struct {
    string       name;
    int unsigned w;
    logic [3:0]  q;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  t_flipflop u_dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .t     (t1),
    .q     (q1),
    .q_bar (qb1)
  );

  t_flipflop #(
    .WIDTH   (4),
    .RST_VAL (4'b1010)
  ) u_dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .t     (t4),
    .q     (q4),
    .q_bar (qb4)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Queue an expectation for the current instant, then step off it so the
  // monitor compares before the driver touches any input.
  task automatic push(input string name, input int unsigned w, input logic [3:0] val);
    exp_t e;
    e.name = name;
    e.w    = w;
    e.q    = val;
    exp_q.push_back(e);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t       e;
    logic [3:0] act_q;
    logic [3:0] act_qb;
    logic [3:0] exp_qv;
    logic [3:0] exp_qb;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      if (e.w == 1) begin
        act_q  = {3'b000, q1};
        act_qb = {3'b000, qb1};
        exp_qv = {3'b000, e.q[0]};
        exp_qb = {3'b000, ~e.q[0]};
      end else begin
        act_q  = q4;
        act_qb = qb4;
        exp_qv = e.q;
        exp_qb = ~e.q;
      end
      check({e.name, "_q"}, act_q, exp_qv);
      check({e.name, "_qbar"}, act_qb, exp_qb);
    end
  end

  // ---------------- driver ----------------
  initial begin
    logic [3:0] tog_exp;
    tog_exp  = 4'b0101;
    n_checks = 0;
    n_pass   = 0;
    rst1_n   = 1'b0;
    rst4_n   = 1'b0;
    t1       = 1'b1;
    t4       = 4'b0110;

    // Reset held with clock running and toggles requested.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push("rst1", 1, 4'b0000);
      push("rst4", 4, 4'b1010);
    end
    @(posedge clk);
    #1;
    push("rst1_posedge", 1, 4'b0000);

    // Release between edges, then toggle for 4 edges: 1,0,1,0.
    @(negedge clk);
    rst1_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      push($sformatf("toggle%0d", k + 1), 1, {3'b000, tog_exp[k]});
    end
    @(negedge clk);
    push("toggle5", 1, 4'b0001);
    t1 = 1'b0;

    // Hold for 3 edges, then a single toggle.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      push($sformatf("hold%0d", k + 1), 1, 4'b0001);
    end
    t1 = 1'b1;
    @(negedge clk);
    push("hold_toggle", 1, 4'b0000);

    // One-edge pulse: exactly one inversion.
    @(negedge clk);
    push("pulse", 1, 4'b0001);
    t1 = 1'b0;
    @(negedge clk);
    push("pulse_after", 1, 4'b0001);

    // Pulse entirely between edges is never sampled.
    #1 t1 = 1'b1;
    #1 t1 = 1'b0;
    @(negedge clk);
    push("glitch", 1, 4'b0001);

    // Async reset mid-cycle with q=1 and t=1.
    t1 = 1'b1;
    #1 rst1_n = 1'b0;
    #1;
    push("async_rst", 1, 4'b0000);
    // Release exactly on a rising edge: the flop must still see reset there.
    @(posedge clk);
    rst1_n <= 1'b1;
    @(negedge clk);
    push("rel_edge", 1, 4'b0000);
    @(negedge clk);
    push("after_rel", 1, 4'b0001);

    // Reset asserted right on a falling edge clears immediately.
    @(negedge clk);
    rst1_n = 1'b0;
    #1;
    push("rst_negedge", 1, 4'b0000);
    t1     = 1'b0;
    rst1_n = 1'b1;
    @(negedge clk);
    push("rst_negedge_hold", 1, 4'b0000);

    // Multi-bit bank, RST_VAL = 1010, bits independent.
    rst4_n = 1'b1;
    @(negedge clk);
    push("mb1", 4, 4'b1100);
    @(negedge clk);
    push("mb2", 4, 4'b1010);
    t4 = 4'b1111;
    @(negedge clk);
    push("mb3", 4, 4'b0101);
    t4 = 4'b0000;
    @(negedge clk);
    push("mb4", 4, 4'b0101);
    t4 = 4'b1001;
    @(negedge clk);
    push("mb5", 4, 4'b1100);
    t4 = 4'b0000;
    #2 rst4_n = 1'b0;
    #1;
    push("mb_async_rst", 4, 4'b1010);

    // Drain the queue with a bounded wait.
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
